// File: rtl/matrix_loader.sv
// matrix_loader: collects one job of N_ELEM elements (matrix A then matrix B,
// row-major) from an upstream valid/ready stream into a register buffer, then
// issues a one-cycle start pulse and streams the buffered elements to the
// matrix multiplier, one per cycle, and waits for the multiplier's done.
//
// Handshake: an upstream element moves only on a rising edge where
// in_valid=1 and in_ready=1; in_ready depends on the loader state only, never
// on in_valid, and in_data is ignored whenever no transfer takes place.
module matrix_loader #(
  parameter int DW     = 8,
  parameter int N_ELEM = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mm_st,
  output logic [DW-1:0] mm_data,
  input  logic          mm_done,
  output logic          busy,
  output logic [4:0]    fill_cnt,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    START     = 2'd1,
    STREAM    = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Index of the final element of a job; both pointers stop here.
  localparam logic [4:0] LAST = 5'(N_ELEM - 1);

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] mem [N_ELEM];
  logic [4:0]    wr_ptr;
  logic [4:0]    rd_ptr;
  logic [4:0]    cnt_q;
  logic          accept;

  // A transfer happens only while filling and the upstream offers data.
  assign accept = in_valid && (state_q == FILL);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control outputs; every output decoded from state only.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    mm_st    = 1'b0;
    busy     = 1'b1;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept && (cnt_q == LAST)) state_d = START;
      end
      START: begin
        mm_st   = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        if (rd_ptr == LAST) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (mm_done) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Pointers and fill count; cleared together when the multiplier finishes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 5'd1;
        cnt_q  <= cnt_q + 5'd1;
      end
      case (state_q)
        FILL: begin
          if (state_d == START) rd_ptr <= '0;
        end
        STREAM: begin
          if (rd_ptr != LAST) rd_ptr <= rd_ptr + 5'd1;
        end
        WAIT_DONE: begin
          if (mm_done) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Element buffer; contents persist across jobs since each job rewrites all.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= in_data;
  end

  assign mm_data   = (state_q == STREAM) ? mem[rd_ptr] : '0;
  assign fill_cnt  = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: reset checks, a per-cycle vector table for one
// full job, directed multi-cycle sequences, and randomized traffic compared
// every cycle against a queue-based job model.
module tb_matrix_loader;

  localparam int DW = 8;
  localparam int NE = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          mm_st;
  logic [DW-1:0] mm_data;
  logic          mm_done = 1'b0;
  logic          busy;
  logic [4:0]    fill_cnt;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  matrix_loader #(.DW(DW), .N_ELEM(NE)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mm_st    (mm_st),
    .mm_data  (mm_data),
    .mm_done  (mm_done),
    .busy     (busy),
    .fill_cnt (fill_cnt),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts accepted elements of the current job; once a job
  // is complete the start pulse is expected, then the job's values in order,
  // then the loader waits for mm_done before counting a new job.
  int            m_cnt = 0;
  bit            m_st  = 1'b0;
  logic [DW-1:0] m_load[$];
  logic [DW-1:0] exp_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = 0;
      m_st  = 1'b0;
      m_load.delete();
      exp_q.delete();
    end else if (m_st) begin
      m_st = 1'b0;
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end else if (m_cnt == NE) begin
      if (mm_done) m_cnt = 0;
    end else if (in_valid) begin
      m_load.push_back(in_data);
      m_cnt++;
      if (m_cnt == NE) begin
        m_st  = 1'b1;
        exp_q = m_load;
        m_load.delete();
      end
    end
  end

  // Scoreboard: compares every cycle's outputs against the model.
  always @(negedge clk) begin
    logic [DW-1:0] e_data;
    #2;
    e_data = (!m_st && exp_q.size() > 0) ? exp_q[0] : '0;
    chk("mon_in_ready", 32'(in_ready), 32'(m_cnt < NE));
    chk("mon_mm_st",    32'(mm_st),    32'(m_st));
    chk("mon_busy",     32'(busy),     32'(m_cnt == NE));
    chk("mon_fill_cnt", 32'(fill_cnt), 32'(m_cnt));
    chk("mon_mm_data",  32'(mm_data),  32'(e_data));
  end

  // Driver: apply inputs for one cycle, leaving time for outputs to settle.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic done);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    mm_done  = done;
    #1;
  endtask

  task automatic load_job(input logic [DW-1:0] d [NE]);
    for (int i = 0; i < NE; i++) begin
      cycle(1'b1, d[i], 1'b0);
      chk("load_fill", 32'(fill_cnt), 32'(i));
    end
    cycle(1'b0, '0, 1'b0);
    chk("start_st", 32'(mm_st), 32'(1));
    chk("start_fill", 32'(fill_cnt), 32'(NE));
  endtask

  task automatic run_job(input logic [DW-1:0] d [NE]);
    load_job(d);
    for (int k = 0; k < NE; k++) begin
      cycle(1'b0, '0, 1'b0);
      chk("job_stream", 32'(mm_data), 32'(d[k]));
    end
    cycle(1'b0, '0, 1'b0);
    chk("job_wait_data", 32'(mm_data), 32'(0));
    chk("job_wait_busy", 32'(busy), 32'(1));
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    chk("job_back_ready", 32'(in_ready), 32'(1));
    chk("job_back_fill", 32'(fill_cnt), 32'(0));
  endtask

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          done;
    logic          e_ready;
    logic          e_st;
    logic [DW-1:0] e_data;
    logic          e_busy;
    logic [4:0]    e_fill;
  } vec_t;

  vec_t          tbl[41];
  logic [DW-1:0] jd [NE];
  logic [DW-1:0] jd2 [NE];
  bit            seen;

  initial begin
    // Vector table for one job of 1..18. Row r's expectations are the
    // outputs in the cycle where row r's inputs are applied.
    for (int i = 0; i < NE; i++)
      tbl[i] = '{1'b1, 8'(i + 1), 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'(i)};
    tbl[18] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 5'd18};
    for (int k = 0; k < NE; k++)
      tbl[19 + k] = '{1'b1, 8'hAA, (k == 6), 1'b0, 1'b0, 8'(k + 1), 1'b1, 5'd18};
    tbl[37] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd18};
    tbl[38] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd18};
    tbl[39] = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5'd18};
    tbl[40] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0};

    // Reset held: outputs at their reset values.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_busy",     32'(busy),     32'(0));
    chk("rst_fill",     32'(fill_cnt), 32'(0));
    chk("rst_mm_st",    32'(mm_st),    32'(0));
    chk("rst_mm_data",  32'(mm_data),  32'(0));
    @(negedge clk);
    rst = 1'b1;

    // Table-driven job, including ignored mm_done and 0xAA offered while busy.
    foreach (tbl[r]) begin
      cycle(tbl[r].v, tbl[r].d, tbl[r].done);
      chk("tbl_in_ready", 32'(in_ready), 32'(tbl[r].e_ready));
      chk("tbl_mm_st",    32'(mm_st),    32'(tbl[r].e_st));
      chk("tbl_mm_data",  32'(mm_data),  32'(tbl[r].e_data));
      chk("tbl_busy",     32'(busy),     32'(tbl[r].e_busy));
      chk("tbl_fill",     32'(fill_cnt), 32'(tbl[r].e_fill));
    end

    // Toggling in_valid: one transfer every other cycle, no early start.
    for (int i = 0; i < 2 * NE - 1; i++) begin
      cycle((i % 2) == 0, 8'($urandom), 1'b0);
      chk("tog_fill", 32'(fill_cnt), 32'((i + 1) / 2));
      chk("tog_no_st", 32'(mm_st), 32'(0));
    end
    cycle(1'b0, '0, 1'b0);
    chk("tog_st", 32'(mm_st), 32'(1));
    chk("tog_fill_full", 32'(fill_cnt), 32'(NE));
    // mm_done held high from the start; only honoured once streaming ends.
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      cycle(1'b0, '0, 1'b1);
      if (in_ready) seen = 1'b1;
    end
    chk("tog_return_bound", 32'(seen), 32'(1));
    cycle(1'b0, '0, 1'b0);

    // Reset in the 7th stream cycle aborts the job at once.
    for (int i = 0; i < NE; i++) jd[i] = 8'($urandom);
    load_job(jd);
    for (int k = 0; k < 7; k++) begin
      cycle(1'b0, '0, 1'b0);
      chk("abort_stream", 32'(mm_data), 32'(jd[k]));
    end
    rst = 1'b0;
    #1;
    chk("abort_mm_data",  32'(mm_data),  32'(0));
    chk("abort_mm_st",    32'(mm_st),    32'(0));
    chk("abort_fill",     32'(fill_cnt), 32'(0));
    chk("abort_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NE; i++) jd[i] = 8'($urandom);
    run_job(jd);

    // Two consecutive jobs; the second shows only its own values.
    for (int i = 0; i < NE; i++) begin
      jd[i]  = 8'(i);
      jd2[i] = 8'(8'hFF - i);
    end
    run_job(jd);
    run_job(jd2);

    // Randomized traffic with occasional resets, checked by the scoreboard.
    for (int n = 0; n < 3000; n++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end

    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter DW, default 8, element width in bits; SHALL match the multiplier data_in width.
REQ-002 Parameter N_ELEM, default 18, elements per job: 9 of matrix A, then 9 of matrix B, row-major.
REQ-003 Port clk, input, 1: the single clock; all state SHALL change on the rising edge only.
REQ-004 Port rst, input, 1: reset is asynchronous and active-low.
REQ-005 Port in_valid, input, 1: upstream element valid.
REQ-006 Port in_data, input, DW: upstream element.
REQ-007 Port in_ready, output, 1: loader accepts in_data this cycle.
REQ-008 Port mm_st, output, 1: start pulse to the multiplier st input.
REQ-009 Port mm_data, output, DW: element stream to the multiplier data_in input.
REQ-010 Port mm_done, input, 1: done from the multiplier.
REQ-011 Port busy, output, 1: high in every state except FILL.
REQ-012 Port fill_cnt, output, 5: number of elements currently buffered (0..N_ELEM).

Function
REQ-013 The block SHALL hold an N_ELEM x DW register buffer, a 5-bit write pointer and a 5-bit read pointer.
REQ-014 The FSM SHALL have exactly four states: FILL, START, STREAM and WAIT_DONE.
REQ-015 In FILL, in_ready SHALL be 1; in all other states, in_ready SHALL be 0.
REQ-016 A transfer SHALL occur only on a cycle where in_valid=1 and in_ready=1; it writes buf[wr_ptr] and increments wr_ptr and fill_cnt.
REQ-017 If in_valid=0, the buffer, wr_ptr and fill_cnt SHALL be unchanged; in_data SHALL be ignored.
REQ-018 The transfer that brings fill_cnt to N_ELEM SHALL move FILL->START on the same edge; no further element SHALL be accepted.
REQ-019 START SHALL last exactly one cycle, with mm_st=1 and rd_ptr=0; it then moves to STREAM.
REQ-020 Timing: if mm_st=1 in cycle T, then mm_data SHALL equal buf[k] in cycle T+1+k, for k=0..N_ELEM-1; rd_ptr increments once per cycle, with no stalls.
REQ-021 After the cycle carrying buf[N_ELEM-1], the FSM SHALL enter WAIT_DONE.
REQ-022 mm_data SHALL be 0 in every cycle outside STREAM.
REQ-023 mm_st SHALL be 0 in every cycle outside START.
REQ-024 WAIT_DONE SHALL hold until a cycle with mm_done=1; it then moves to FILL and clears wr_ptr, rd_ptr and fill_cnt on that edge.
REQ-025 mm_done=1 in FILL, START or STREAM SHALL be ignored and SHALL NOT be remembered.
REQ-026 Buffer contents SHALL NOT be cleared between jobs; every job overwrites all N_ELEM entries before streaming.
REQ-027 Pointers SHALL never wrap: wr_ptr saturates at N_ELEM via the state change, and rd_ptr is reset on entry to START.
REQ-028 fill_cnt SHALL remain N_ELEM through START, STREAM and WAIT_DONE.
REQ-029 Latency: the last accepted element on edge E gives mm_st=1 in the cycle after E.

Reset
REQ-030 While rst=0, regardless of clk: state=FILL, wr_ptr=0, rd_ptr=0, fill_cnt=0, mm_st=0, mm_data=0, busy=0, in_ready=1.
REQ-031 Buffer contents SHALL NOT need a reset value.
REQ-032 Reset asserted in any state, including mid-STREAM, SHALL abort the job immediately with no further mm_st or mm_data activity.
REQ-033 After rst rises, the first transfer SHALL be accepted on the first rising edge with in_valid=1.

Verification
REQ-034 Load 1..18 back-to-back with in_valid held at 1 -> mm_st=1 one cycle after the 18th accept; mm_data=1,2,...,18 on the next 18 cycles; then mm_data=0 and busy=1.
REQ-035 Load 18 elements with in_valid toggling 1,0,1,0,... -> exactly 18 transfers, fill_cnt steps 0..18, and no mm_st before the 18th transfer.
REQ-036 Pulse mm_done=1 during STREAM, then hold it at 0 -> the FSM remains in WAIT_DONE; a later mm_done=1 pulse returns it to FILL with fill_cnt=0 and in_ready=1 the next cycle.
REQ-037 Drive in_valid=1 with data 0xAA during START, STREAM and WAIT_DONE -> in_ready=0 throughout, and no 0xAA ever appears on mm_data.
REQ-038 Drop rst to 0 for a cycle at the 7th STREAM cycle -> mm_data=0, mm_st=0, fill_cnt=0 and in_ready=1 immediately; a following 18-element job streams correctly.
REQ-039 Run two consecutive jobs with data 0x00..0x11, then 0xFF..0xEE -> the second stream shows only new values, in order.
